// File: rtl/serial_arbiter.sv
// serial_arbiter
//   Round-robin arbiter that lends one shared parallel-to-serial converter to
//   four word-oriented requesters. At most one requester owns the converter at
//   a time. The owner's word and request level are presented on par_data and
//   par_ready. The converter's consume pulse is routed back to the requester
//   that owned the word when the converter sampled it.
//
//   Optional feature: define ARB_BURST_LIMIT_EN to force release of a grant
//   after MAX_BURST consumed words, even while the owner still requests.
//
// Ports
//   clk         in   single clock, all state on posedge
//   reset       in   asynchronous active-high reset
//   req[3:0]    in   per-requester word-available level
//   req_data    in   requester i word on [i*WIDTH +: WIDTH]
//   req_strobe  out  one-cycle "word consumed" pulse to requester i
//   grant[3:0]  out  registered one-hot owner, zero when idle
//   par_data    out  owner's word to converter (zero when idle)
//   par_ready   out  owner's request level to converter (zero when idle)
//   par_strobe  in   converter pulse, one cycle after it samples par_data
module serial_arbiter #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         req,
  input  logic [4*WIDTH-1:0] req_data,
  output logic [3:0]         req_strobe,
  output logic [3:0]         grant,
  output logic [WIDTH-1:0]   par_data,
  output logic               par_ready,
  input  logic               par_strobe
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACTIVE = 1'b1;

  logic [0:0] r_state;
  logic [0:0] w_state_nx;
  logic [3:0] r_grant;
  logic [3:0] w_grant_nx;
  logic [1:0] r_last_grant;
  logic [1:0] w_last_grant_nx;
  logic [3:0] r_strobe_owner;
  logic [1:0] w_gidx;
  logic [1:0] w_rr_idx;
  logic [1:0] w_cand;
  logic       w_rr_found;
  logic       w_burst_stop;

  // One-hot grant to owner index
  always_comb begin
    w_gidx = 2'd0;
    case (r_grant)
      4'b0010: w_gidx = 2'd1;
      4'b0100: w_gidx = 2'd2;
      4'b1000: w_gidx = 2'd3;
      default: w_gidx = 2'd0;
    endcase
  end

  // Round-robin search starting just after the previous owner, wrapping;
  // k = 4 lands back on the previous owner as the lowest-priority candidate
  always_comb begin
    w_rr_idx   = 2'd0;
    w_rr_found = 1'b0;
    w_cand     = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      w_cand = r_last_grant + 2'(k);
      if (!w_rr_found && req[w_cand]) begin
        w_rr_idx   = w_cand;
        w_rr_found = 1'b1;
      end
    end
  end

  // Next-state / next-grant
  always_comb begin
    w_state_nx      = r_state;
    w_grant_nx      = r_grant;
    w_last_grant_nx = r_last_grant;
    case (r_state)
      S_IDLE: begin
        if (w_rr_found) begin
          w_state_nx = S_ACTIVE;
          w_grant_nx = 4'b0001 << w_rr_idx;
        end
      end
      S_ACTIVE: begin
        // Releasing always passes through IDLE, giving one idle cycle between grants
        if (!req[w_gidx] || w_burst_stop) begin
          w_state_nx      = S_IDLE;
          w_grant_nx      = 4'b0000;
          w_last_grant_nx = w_gidx;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_grant_nx = 4'b0000;
      end
    endcase
  end

  // State register; strobe_owner trails grant so the last word's pulse still
  // reaches its requester after the grant has cleared
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_grant        <= 4'b0000;
      r_last_grant   <= 2'd3;
      r_strobe_owner <= 4'b0000;
    end else begin
      r_state        <= w_state_nx;
      r_grant        <= w_grant_nx;
      r_last_grant   <= w_last_grant_nx;
      r_strobe_owner <= r_grant;
    end
  end

`ifdef ARB_BURST_LIMIT_EN
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  logic [CNT_W-1:0] r_burst_cnt;
  logic             r_burst_stop;

  // Count consumed words of the current grant; once the final allowed word is
  // offered, withdraw par_ready and release on the following edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_burst_cnt  <= '0;
      r_burst_stop <= 1'b0;
    end else if (r_state == S_IDLE) begin
      r_burst_cnt  <= '0;
      r_burst_stop <= 1'b0;
    end else begin
      if (|(req_strobe & r_grant)) begin
        r_burst_cnt <= r_burst_cnt + CNT_W'(1);
      end
      if ((r_burst_cnt == CNT_W'(MAX_BURST - 1)) && par_ready) begin
        r_burst_stop <= 1'b1;
      end
    end
  end

  assign w_burst_stop = r_burst_stop;
`else
  // Limit compiled out: MAX_BURST has no effect on behaviour
  assign w_burst_stop = (MAX_BURST == 0) & 1'b0;
`endif

  assign grant      = r_grant;
  assign req_strobe = r_strobe_owner & {4{par_strobe}};
  assign par_ready  = (r_state == S_ACTIVE) && req[w_gidx] && !w_burst_stop;
  assign par_data   = (r_state == S_ACTIVE) ? req_data[w_gidx*WIDTH +: WIDTH] : '0;

endmodule

// File: tb/tb_serial_arbiter.sv
module tb_serial_arbiter;

  localparam int unsigned W  = 8;
  localparam int unsigned MB = 4;
`ifdef ARB_BURST_LIMIT_EN
  localparam bit BURST_EN = 1'b1;
`else
  localparam bit BURST_EN = 1'b0;
`endif

  logic           clk        = 1'b0;
  logic           reset      = 1'b1;
  logic [3:0]     req        = 4'b0000;
  logic [4*W-1:0] req_data   = '0;
  logic           par_strobe = 1'b0;
  logic [3:0]     req_strobe;
  logic [3:0]     grant;
  logic [W-1:0]   par_data;
  logic           par_ready;

  int checks   = 0;
  int failures = 0;

  serial_arbiter #(.WIDTH(W), .MAX_BURST(MB)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_data   (req_data),
    .req_strobe (req_strobe),
    .grant      (grant),
    .par_data   (par_data),
    .par_ready  (par_ready),
    .par_strobe (par_strobe)
  );

  always #5 clk = ~clk;

  // Requester word queues (ring buffers) and reference model state
  logic [7:0] mem [4][64];
  int hd [4];
  int tl [4];
  int m_owner;      // -1 when idle
  int m_last;
  int m_strobes;    // words confirmed to current owner
  bit m_stop;       // burst limit reached, release pending
  bit cur_pstb;
  int ser_owner;    // owner of the word the converter last sampled
  int act_stb_cnt [4];
  int samp_log [$];
  logic [3:0] gnt_log [$];

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      hd[i] = 0; tl[i] = 0; act_stb_cnt[i] = 0;
    end
    m_owner = -1; m_last = 3; m_strobes = 0; m_stop = 1'b0;
    cur_pstb = 1'b0; ser_owner = 0;
    samp_log.delete();
    gnt_log.delete();
  endtask

  task automatic push_word(input int r, input logic [7:0] w);
    if (tl[r] - hd[r] < 60) begin
      mem[r][tl[r] % 64] = w;
      tl[r]++;
    end
  endtask

  // Ends one time unit after a rising edge with reset released
  task automatic do_reset();
    reset = 1'b1; req = 4'b0000; req_data = '0; par_strobe = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_clear();
  endtask

  // Bench acts as the four requesters and the converter; every cycle the DUT
  // is compared against the arbitration rules applied to bench-held state
  task automatic run_harness(input int ncyc, input int accept_pct, input int fill_pct);
    logic [3:0]     cur_req;
    logic [4*W-1:0] cur_data;
    logic [3:0]     exp_grant;
    logic [3:0]     exp_stb;
    logic [W-1:0]   exp_data;
    logic           exp_ready;
    bit             sampled;
    int             owner_before;
    for (int c = 0; c < ncyc; c++) begin
      cur_req = 4'b0000;
      for (int i = 0; i < 4; i++) begin
        if (tl[i] != hd[i]) begin
          cur_req[i] = 1'b1;
          cur_data[i*W +: W] = mem[i][hd[i] % 64];
        end else begin
          cur_data[i*W +: W] = W'($urandom);
        end
      end
      req = cur_req; req_data = cur_data; par_strobe = cur_pstb;
      exp_grant = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
      exp_ready = (m_owner >= 0) ? (cur_req[m_owner[1:0]] && !m_stop) : 1'b0;
      exp_data  = (m_owner >= 0) ? cur_data[m_owner*W +: W] : '0;
      exp_stb   = cur_pstb ? 4'(1 << ser_owner) : 4'b0000;
      @(negedge clk);
      checks++;
      if (grant !== exp_grant) begin
        failures++; $display("FAIL grant cyc=%0d got=%b exp=%b", c, grant, exp_grant);
      end
      checks++;
      if (par_ready !== exp_ready) begin
        failures++; $display("FAIL par_ready cyc=%0d got=%b exp=%b", c, par_ready, exp_ready);
      end
      checks++;
      if (par_data !== exp_data) begin
        failures++; $display("FAIL par_data cyc=%0d got=%h exp=%h", c, par_data, exp_data);
      end
      checks++;
      if (req_strobe !== exp_stb) begin
        failures++; $display("FAIL req_strobe cyc=%0d got=%b exp=%b", c, req_strobe, exp_stb);
      end
      gnt_log.push_back(grant);
      for (int i = 0; i < 4; i++) if (req_strobe[i] === 1'b1) act_stb_cnt[i]++;
      sampled = exp_ready && !cur_pstb && ($urandom_range(0, 99) < accept_pct);
      if (sampled) samp_log.push_back(m_owner);
      @(posedge clk);
      for (int i = 0; i < 4; i++) if (exp_stb[i]) hd[i]++;
      owner_before = m_owner;
      if (m_owner < 0) begin
        if (cur_req != 4'b0000) begin
          for (int k = 1; k <= 4; k++) begin
            int idx;
            idx = (m_last + k) % 4;
            if (m_owner < 0 && cur_req[idx]) m_owner = idx;
          end
          m_strobes = 0; m_stop = 1'b0;
        end
      end else if (!cur_req[m_owner[1:0]] || m_stop) begin
        m_last = m_owner; m_owner = -1; m_stop = 1'b0;
      end else begin
        if (BURST_EN && exp_ready && (m_strobes == MB - 1)) m_stop = 1'b1;
        if (exp_stb[m_owner[1:0]]) m_strobes++;
      end
      cur_pstb = sampled;
      if (sampled) ser_owner = owner_before;
      if (fill_pct > 0 && $urandom_range(0, 99) < fill_pct)
        push_word(int'($urandom_range(0, 3)), 8'($urandom));
      #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 4'b1111; req_data = 32'hDEADBEEF; par_strobe = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (grant !== 4'b0000) begin failures++; $display("FAIL reset_grant got=%b exp=0000", grant); end
    checks++;
    if (par_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", par_ready); end
    checks++;
    if (par_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", par_data); end
    checks++;
    if (req_strobe !== 4'b0000) begin failures++; $display("FAIL reset_strobe got=%b exp=0000", req_strobe); end
  endtask

  task automatic test_single_word();
    do_reset();
    req = 4'b0001; req_data = {24'h0, 8'hA5};
    @(negedge clk);
    checks++;
    if (grant !== 4'b0000) begin failures++; $display("FAIL single_pre_grant got=%b exp=0000", grant); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (grant !== 4'b0001) begin failures++; $display("FAIL single_grant got=%b exp=0001", grant); end
    checks++;
    if (par_ready !== 1'b1) begin failures++; $display("FAIL single_ready got=%b exp=1", par_ready); end
    checks++;
    if (par_data !== 8'hA5) begin failures++; $display("FAIL single_data got=%h exp=a5", par_data); end
    @(posedge clk); #1 par_strobe = 1'b1;
    @(negedge clk);
    checks++;
    if (req_strobe !== 4'b0001) begin failures++; $display("FAIL single_strobe got=%b exp=0001", req_strobe); end
    @(posedge clk); #1 par_strobe = 1'b0; req = 4'b0000;
    @(negedge clk);
    checks++;
    if (req_strobe !== 4'b0000) begin failures++; $display("FAIL single_strobe_end got=%b exp=0000", req_strobe); end
  endtask

  task automatic test_round_robin();
    logic [3:0] comp [$];
    logic [3:0] exp_seq [9];
    int zrun;
    do_reset();
    for (int i = 0; i < 4; i++) push_word(i, 8'(8'h10 + i));
    run_harness(40, 100, 0);
    exp_seq = '{4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0};
    zrun = 0;
    foreach (gnt_log[j]) begin
      if (j == 0 || gnt_log[j] != gnt_log[j-1]) comp.push_back(gnt_log[j]);
      if (gnt_log[j] == 4'h0) zrun++;
      else begin
        if (j > 0 && gnt_log[j-1] == 4'h0 && comp.size() > 2) begin
          checks++;
          if (zrun != 1) begin failures++; $display("FAIL rr_idle_gap got=%0d exp=1", zrun); end
        end
        zrun = 0;
      end
    end
    checks++;
    if (comp.size() != 9) begin
      failures++; $display("FAIL rr_seq_len got=%0d exp=9", comp.size());
    end else begin
      for (int j = 0; j < 9; j++) begin
        checks++;
        if (comp[j] !== exp_seq[j]) begin
          failures++; $display("FAIL rr_seq[%0d] got=%b exp=%b", j, comp[j], exp_seq[j]);
        end
      end
    end
  endtask

  task automatic test_multi_word();
    int exp_cnt [4];
    do_reset();
    push_word(2, 8'hC1); push_word(2, 8'hC2); push_word(2, 8'hC3);
    run_harness(30, 70, 0);
    exp_cnt = '{0, 0, 3, 0};
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (act_stb_cnt[i] != exp_cnt[i]) begin
        failures++; $display("FAIL multi_strobes[%0d] got=%0d exp=%0d", i, act_stb_cnt[i], exp_cnt[i]);
      end
    end
    checks++;
    if (grant !== 4'b0000) begin failures++; $display("FAIL multi_final_grant got=%b exp=0000", grant); end
  endtask

  task automatic test_burst();
    int lead;
    int exp_lead;
    do_reset();
    for (int j = 0; j < 8; j++) begin
      push_word(0, 8'(8'hA0 + j));
      push_word(1, 8'(8'hB0 + j));
    end
    run_harness(60, 100, 0);
    lead = 0;
    while (lead < samp_log.size() && samp_log[lead] == 0) lead++;
    exp_lead = BURST_EN ? 4 : 8;
    checks++;
    if (lead != exp_lead) begin failures++; $display("FAIL burst_words_r0 got=%0d exp=%0d", lead, exp_lead); end
    checks++;
    if (lead >= samp_log.size() || samp_log[lead] != 1) begin
      failures++; $display("FAIL burst_next_owner got=%0d exp=1", (lead < samp_log.size()) ? samp_log[lead] : -1);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 4'b0100; req_data = {8'h00, 8'h3C, 16'h0000};
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (grant !== 4'b0100) begin failures++; $display("FAIL mid_grant got=%b exp=0100", grant); end
    @(posedge clk); #1 par_strobe = 1'b1;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (grant !== 4'b0000) begin failures++; $display("FAIL mid_reset_grant got=%b exp=0000", grant); end
    checks++;
    if (par_ready !== 1'b0) begin failures++; $display("FAIL mid_reset_ready got=%b exp=0", par_ready); end
    checks++;
    if (req_strobe !== 4'b0000) begin failures++; $display("FAIL mid_reset_strobe got=%b exp=0000", req_strobe); end
    @(posedge clk); #1 reset = 1'b0; par_strobe = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (grant !== 4'b0100) begin failures++; $display("FAIL mid_regrant got=%b exp=0100", grant); end
    req = 4'b0000;
  endtask

  task automatic test_idle_strobe();
    do_reset();
    par_strobe = 1'b1;
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      checks++;
      if (req_strobe !== 4'b0000) begin failures++; $display("FAIL idle_strobe[%0d] got=%b exp=0000", j, req_strobe); end
      @(posedge clk); #1;
    end
    par_strobe = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      int n;
      n = int'($urandom_range(0, 4));
      for (int j = 0; j < n; j++) push_word(i, 8'($urandom));
    end
    run_harness(800, 75, 20);
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_round_robin();
    test_multi_word();
    test_burst();
    test_reset_mid();
    test_idle_strobe();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
